ps2_key_encoder: RTL and testbench

- Generates key events on the HPS-style 65-bit ps2_key bus from a queued stream of {extended, scancode, pressed} requests. It is the transmit-side counterpart of the keyboard decoder in the core top level.
- Used by on-screen/joystick-to-key remapping and by benches to drive cores exactly as hps_io would.
- Requests are buffered in a small FIFO and serialised into the scancode byte-history format.
- Each completed event is published atomically with a toggle of bit 64, and events are paced by a programmable gap.

---
 rtl/ps2_key_encoder.sv | 162 ++++++++++++++++
 tb/tb_ps2_key_encoder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: turns queued {extended, scancode, pressed} requests into
// events on the 65-bit ps2_key bus (bit 64 toggles once per event, bits
// [63:0] hold the byte history with the newest byte in [7:0]).
//
// Input handshake: a request transfers on a rising clk_sys edge where
// in_valid && in_ready. in_ready depends only on registered FIFO state (and is
// held low while reset is high), never on in_valid, so the source may change
// its request freely while in_ready is low. A pop in the same cycle does not
// open a slot for a push while the FIFO is full.
module ps2_key_encoder #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  in_code,
  input  logic        in_pressed,
  output logic [64:0] ps2_key,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SHIFT   = 2'd1,
    S_PUBLISH = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Request FIFO: entry = {pressed, extended, scancode}
  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Serialiser state
  logic [63:0]   r_shadow;
  logic [23:0]   r_seq;      // pending bytes, next one in [23:16]
  logic [1:0]    r_left;     // bytes still to shift
  logic [GW-1:0] r_gap_cnt;
  logic [64:0]   r_ps2_key;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [9:0]    w_head;
  logic [23:0]   w_seq;
  logic [1:0]    w_len;

  assign w_full   = (r_count == FULL_COUNT);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full && !reset;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;
  assign w_head   = r_mem[r_rd_ptr];

  assign ps2_key  = r_ps2_key;
  assign busy     = (r_state != S_IDLE) || !w_empty;

  // Build the left-aligned byte sequence for the FIFO head (oldest byte first)
  always_comb begin
    w_seq = {w_head[7:0], 16'h0000};
    w_len = 2'd1;
    if (w_head[8] && !w_head[9]) begin
      w_seq = {8'hE0, 8'hF0, w_head[7:0]};
      w_len = 2'd3;
    end else if (w_head[8]) begin
      w_seq = {8'hE0, w_head[7:0], 8'h00};
      w_len = 2'd2;
    end else if (!w_head[9]) begin
      w_seq = {8'hF0, w_head[7:0], 8'h00};
      w_len = 2'd2;
    end
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_pressed, in_code};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:    if (!w_empty) w_next_state = S_SHIFT;
      S_SHIFT:   if (r_left == 2'd1) w_next_state = S_PUBLISH;
      S_PUBLISH: w_next_state = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:     if (r_gap_cnt == '0) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Serialiser datapath: latch, shift into a cleared shadow, publish atomically
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_shadow  <= '0;
      r_seq     <= '0;
      r_left    <= '0;
      r_gap_cnt <= '0;
      r_ps2_key <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shadow <= '0;
            r_seq    <= w_seq;
            r_left   <= w_len;
          end
        end
        S_SHIFT: begin
          r_shadow <= {r_shadow[55:0], r_seq[23:16]};
          r_seq    <= {r_seq[15:0], 8'h00};
          r_left   <= r_left - 2'd1;
        end
        S_PUBLISH: begin
          r_ps2_key <= {~r_ps2_key[64], r_shadow};
          r_gap_cnt <= GAP_LOAD;
        end
        S_GAP: begin
          r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: one instance with GAP_CYCLES=16, one with 0.
module tb_ps2_key_encoder;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;

  // Clock and reset
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  logic reset = 1'b1;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic        va = 0, pa = 0, ra, ba;
  logic [8:0]  ca = '0;
  logic [64:0] ka;
  logic        vb = 0, pb = 0, rb, bb;
  logic [8:0]  cb = '0;
  logic [64:0] kb;

  ps2_key_encoder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk_sys(clk_sys), .reset(reset), .in_valid(va), .in_ready(ra),
    .in_code(ca), .in_pressed(pa), .ps2_key(ka), .busy(ba)
  );

  ps2_key_encoder #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .in_valid(vb), .in_ready(rb),
    .in_code(cb), .in_pressed(pb), .ps2_key(kb), .busy(bb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic tog_a = 0;
  logic tog_b = 0;

  // Scoreboard state
  logic [63:0] exp_q[$];
  int          exp_n_q[$];
  int          ev_cyc[$];
  logic [64:0] ev_val[$];
  bit          ev_timeout;

  // Reference model: byte list E0? F0? code, folded oldest-first into history
  function automatic logic [63:0] model_hist(input logic [8:0] c, input logic p);
    logic [7:0]  q[$];
    logic [63:0] h;
    h = '0;
    if (c[8]) q.push_back(8'hE0);
    if (!p)   q.push_back(8'hF0);
    q.push_back(c[7:0]);
    foreach (q[i]) h = (h << 8) | 64'(q[i]);
    return h;
  endfunction

  function automatic int model_len(input logic [8:0] c, input logic p);
    return 1 + (c[8] ? 1 : 0) + (p ? 0 : 1);
  endfunction

  function automatic logic [64:0] get_key(input int sel);
    return (sel == 0) ? ka : kb;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Records toggles of bit 64 (cycle and value) without judging them
  task automatic collect_events(input int sel, input int count, input int budget);
    logic [64:0] k;
    logic p;
    int waited;
    waited = 0;
    ev_cyc.delete();
    ev_val.delete();
    ev_timeout = 0;
    k = get_key(sel);
    p = k[64];
    while (ev_cyc.size() < count) begin
      if (waited >= budget) begin
        ev_timeout = 1;
        break;
      end
      tick();
      waited++;
      k = get_key(sel);
      if (k[64] !== p) begin
        ev_cyc.push_back(cyc);
        ev_val.push_back(k);
        p = k[64];
      end
    end
  endtask

  task automatic wait_idle_a();
    int w;
    w = 0;
    while (ba === 1'b1 && w < 80) begin
      tick();
      w++;
    end
    n_tests++;
    if (ba !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: busy=%b required 0", ba);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    va = 0;
    vb = 0;
    repeat (3) tick();
    n_tests++; if (ra !== 1'b0) begin n_fail++; $display("FAIL rst_ready_a: got %b exp 0", ra); end
    n_tests++; if (rb !== 1'b0) begin n_fail++; $display("FAIL rst_ready_b: got %b exp 0", rb); end
    n_tests++; if (ka !== 65'd0) begin n_fail++; $display("FAIL rst_key_a: got %h exp 0", ka); end
    n_tests++; if (kb !== 65'd0) begin n_fail++; $display("FAIL rst_key_b: got %h exp 0", kb); end
    n_tests++; if (ba !== 1'b0 || bb !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b%b exp 00", ba, bb); end
    reset = 0;
    tick();
    n_tests++; if (ra !== 1'b1 || rb !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b%b exp 11", ra, rb); end
    n_tests++; if (ka !== 65'd0 || ba !== 1'b0) begin n_fail++; $display("FAIL post_rst_state: key %h busy %b exp 0/0", ka, ba); end
    tog_a = 0;
    tog_b = 0;
  endtask

  // Single request on the GAP=16 instance; checks latency and value
  task automatic test_single(input logic [8:0] c, input logic p, input string nm);
    int acc;
    logic [63:0] eh;
    int en;
    eh = model_hist(c, p);
    en = model_len(c, p);
    ca = c;
    pa = p;
    va = 1;
    n_tests++; if (ra !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b exp 1", nm, ra); end
    tick();
    acc = cyc;
    va = 0;
    collect_events(0, 1, 40);
    tog_a = ~tog_a;
    n_tests++;
    if (ev_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL %s_event: got %0d events exp 1", nm, ev_cyc.size());
    end else begin
      n_tests++; if (ev_cyc[0] - acc != 2 + en) begin n_fail++; $display("FAIL %s_latency: got %0d exp %0d", nm, ev_cyc[0] - acc, 2 + en); end
      n_tests++; if (ev_val[0] !== {tog_a, eh}) begin n_fail++; $display("FAIL %s_value: got %h exp %h", nm, ev_val[0], {tog_a, eh}); end
      n_tests++; if (ev_val[0][63:24] !== 40'd0) begin n_fail++; $display("FAIL %s_upper: got %h exp 0", nm, ev_val[0][63:24]); end
    end
  endtask

  task automatic test_single_make();
    test_single(9'h029, 1'b1, "make029");
    // busy must hold through the whole gap and drop right after it
    repeat (GAP - 1) tick();
    n_tests++; if (ba !== 1'b1) begin n_fail++; $display("FAIL gap_busy_hold: got %b exp 1", ba); end
    tick();
    n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL gap_busy_drop: got %b exp 0", ba); end
  endtask

  task automatic test_ext_break();
    test_single(9'h175, 1'b0, "brk175");
    n_tests++; if (ka[23:16] !== 8'hE0 || ka[15:8] !== 8'hF0) begin n_fail++; $display("FAIL brk175_compat: got %h exp e0f0", ka[23:8]); end
    wait_idle_a();
  endtask

  task automatic drive_burst(input int n, output int acc_cyc[8], output int first_stall);
    bit rdy;
    int w;
    first_stall = -1;
    for (int i = 0; i < n; i++) begin
      ca = exp_q.size() > 0 ? ca : ca;
      va = 1;
      w = 0;
      acc_cyc[i] = -1;
      while (w < 200) begin
        rdy = ra;
        tick();
        w++;
        if (rdy) begin
          acc_cyc[i] = cyc;
          break;
        end
        if (first_stall < 0) first_stall = i;
      end
    end
    va = 0;
  endtask

  task automatic test_back_to_back();
    logic [8:0] rc[8];
    logic       rp[8];
    int         acc_cyc[8];
    int         first_stall;
    int         rn[8];
    bit         rdy;
    int         w;
    for (int i = 0; i < DEPTH + 2; i++) begin
      rc[i] = 9'($urandom_range(0, 511));
      rp[i] = 1'($urandom_range(0, 1));
      rn[i] = model_len(rc[i], rp[i]);
    end
    first_stall = -1;
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) begin
          ca = rc[i];
          pa = rp[i];
          va = 1;
          w = 0;
          acc_cyc[i] = -1;
          while (w < 200) begin
            rdy = ra;
            tick();
            w++;
            if (rdy) begin
              acc_cyc[i] = cyc;
              break;
            end
            if (first_stall < 0) first_stall = i;
          end
        end
        va = 0;
      end
      collect_events(0, DEPTH + 2, 250);
    join
    n_tests++; if (first_stall != DEPTH + 1) begin n_fail++; $display("FAIL b2b_first_stall: got %0d exp %0d", first_stall, DEPTH + 1); end
    n_tests++;
    if (ev_cyc.size() != DEPTH + 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d exp %0d", ev_cyc.size(), DEPTH + 2);
    end else begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        tog_a = ~tog_a;
        n_tests++;
        if (ev_val[i] !== {tog_a, model_hist(rc[i], rp[i])}) begin
          n_fail++;
          $display("FAIL b2b_value[%0d]: got %h exp %h", i, ev_val[i], {tog_a, model_hist(rc[i], rp[i])});
        end
        if (i > 0) begin
          n_tests++;
          if (ev_cyc[i] - ev_cyc[i-1] != GAP + rn[i] + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: got %0d exp %0d", i, ev_cyc[i] - ev_cyc[i-1], GAP + rn[i] + 2);
          end
        end
      end
      n_tests++; if (ev_cyc[0] - acc_cyc[0] != 2 + rn[0]) begin n_fail++; $display("FAIL b2b_latency: got %0d exp %0d", ev_cyc[0] - acc_cyc[0], 2 + rn[0]); end
      // the slot freed by the second pop is not usable in the pop cycle itself
      n_tests++; if (acc_cyc[DEPTH+1] != ev_cyc[0] + GAP + 2) begin n_fail++; $display("FAIL b2b_full_pop_accept: got %0d exp %0d", acc_cyc[DEPTH+1], ev_cyc[0] + GAP + 2); end
    end
    wait_idle_a();
  endtask

  task automatic test_gap0();
    int acc0, acc1;
    cb = 9'h014;
    pb = 1;
    vb = 1;
    tick();
    acc0 = cyc;
    n_tests++; if (rb !== 1'b1) begin n_fail++; $display("FAIL gap0_ready: got %b exp 1", rb); end
    pb = 0;
    tick();
    acc1 = cyc;
    vb = 0;
    collect_events(1, 2, 30);
    n_tests++;
    if (ev_cyc.size() != 2) begin
      n_fail++;
      $display("FAIL gap0_count: got %0d exp 2", ev_cyc.size());
    end else begin
      n_tests++; if (ev_cyc[0] - acc0 != 3) begin n_fail++; $display("FAIL gap0_lat: got %0d exp 3", ev_cyc[0] - acc0); end
      n_tests++; if (ev_cyc[1] - ev_cyc[0] != 4) begin n_fail++; $display("FAIL gap0_spacing: got %0d exp 4", ev_cyc[1] - ev_cyc[0]); end
      n_tests++; if (ev_val[0] !== {1'b1, 64'h14}) begin n_fail++; $display("FAIL gap0_make: got %h exp %h", ev_val[0], {1'b1, 64'h14}); end
      n_tests++; if (ev_val[1] !== {1'b0, 64'hF014}) begin n_fail++; $display("FAIL gap0_break: got %h exp %h", ev_val[1], {1'b0, 64'hF014}); end
      n_tests++; if (acc1 - acc0 != 1) begin n_fail++; $display("FAIL gap0_accept: got %0d exp 1", acc1 - acc0); end
    end
    tog_b = 0;
  endtask

  task automatic test_reset_mid();
    logic [8:0] c3[3];
    logic       p3[3];
    c3[0] = 9'h16B; p3[0] = 0;
    c3[1] = 9'h01C; p3[1] = 1;
    c3[2] = 9'h023; p3[2] = 1;
    for (int i = 0; i < 3; i++) begin
      ca = c3[i];
      pa = p3[i];
      va = 1;
      n_tests++; if (ra !== 1'b1) begin n_fail++; $display("FAIL mid_ready[%0d]: got %b exp 1", i, ra); end
      tick();
    end
    va = 0;
    reset = 1;
    tick();
    tick();
    n_tests++; if (ka !== 65'd0) begin n_fail++; $display("FAIL mid_key: got %h exp 0", ka); end
    n_tests++; if (ba !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b exp 0", ba); end
    n_tests++; if (ra !== 1'b0) begin n_fail++; $display("FAIL mid_ready_rst: got %b exp 0", ra); end
    reset = 0;
    tick();
    n_tests++; if (ra !== 1'b1) begin n_fail++; $display("FAIL mid_ready_rel: got %b exp 1", ra); end
    tog_a = 0;
    tog_b = 0;
    collect_events(0, 1, 40);
    n_tests++; if (ev_cyc.size() != 0 || ka !== 65'd0 || ba !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got %0d events key %h busy %b exp 0/0/0", ev_cyc.size(), ka, ba); end
  endtask

  task automatic test_random();
    logic [8:0] rc[8];
    logic       rp[8];
    bit         rdy;
    int         w;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      rc[i] = 9'($urandom_range(0, 511));
      rp[i] = 1'($urandom_range(0, 1));
    end
    rc[0] = 9'h000;
    rp[0] = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(model_hist(rc[i], rp[i]));
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          ca = rc[i];
          pa = rp[i];
          va = 1;
          w = 0;
          while (w < 100) begin
            rdy = ra;
            tick();
            w++;
            if (rdy) break;
          end
          va = 0;
        end
      end
      collect_events(0, 8, 450);
    join
    n_tests++;
    if (ev_cyc.size() != 8) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d exp 8", ev_cyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        tog_a = ~tog_a;
        n_tests++; if (ev_val[i] !== {tog_a, e}) begin n_fail++; $display("FAIL rnd_value[%0d]: got %h exp %h", i, ev_val[i], {tog_a, e}); end
        n_tests++; if (ev_val[i][63:24] !== 40'd0) begin n_fail++; $display("FAIL rnd_upper[%0d]: got %h exp 0", i, ev_val[i][63:24]); end
      end
    end
    wait_idle_a();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_make();
    test_ext_break();
    test_back_to_back();
    test_gap0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
